// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: word geometry and FSM states.
package imem_pkg;

    localparam int INSN_W     = 32;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } imem_loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Word stream into the loader plus the instruction-memory write port it drives.
interface imem_loader_if;
    import imem_pkg::*;

    // Stream: a word transfers on a rising edge where in_valid && in_ready are both high.
    // in_data/in_last must stay stable while in_valid is high and in_ready is low.
    logic              in_valid;
    logic [INSN_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;

    logic              WE;
    logic [INSN_W-1:0] W_Ins;
    logic [31:0]       newPC;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, WE, W_Ins, newPC
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, WE, W_Ins, newPC
    );

endinterface

// File: rtl/imem_loader.sv
// Streams a program image into instruction memory after reset, holding fetch while it loads.
// Optional running checksum of written words: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          core_hold,
    output logic          done,
    output logic          err,
    output logic [31:0]   word_count,
    output logic [31:0]   checksum,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0]  S_IDLE  = 2'(IDLE);
    localparam logic [1:0]  S_LOAD  = 2'(LOAD);
    localparam logic [1:0]  S_DONE  = 2'(DONE);
    localparam logic [1:0]  S_ERROR = 2'(ERROR);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);
    localparam logic [31:0] STRIDE  = 32'(WORD_BYTES);

    logic [1:0]  state_q;
    logic [31:0] addr_q;
    logic        full;
    logic        accept;
    logic        overflow;
    logic        restart;

    // Once the memory is full the loader refuses further words; an offered word then means overflow.
    assign full         = (word_count == DEPTH_W);
    assign bus.in_ready = (state_q == S_LOAD) && !full;
    assign accept       = bus.in_valid && bus.in_ready;
    assign overflow     = (state_q == S_LOAD) && bus.in_valid && full;
    assign restart      = start && (state_q != S_LOAD);
    assign dbg_state    = state_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            word_count <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            core_hold  <= 1'b0;
            bus.WE     <= 1'b0;
            bus.W_Ins  <= '0;
            bus.newPC  <= '0;
        end else begin
            bus.WE <= accept;
            if (accept) begin
                bus.W_Ins  <= bus.in_data;
                bus.newPC  <= addr_q;
                addr_q     <= addr_q + STRIDE;
                word_count <= word_count + 32'd1;
            end
            if (restart) begin
                state_q    <= S_LOAD;
                addr_q     <= BASE_ADDR;
                word_count <= '0;
                done       <= 1'b0;
                err        <= 1'b0;
                core_hold  <= 1'b1;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        if (overflow) begin
                            state_q <= S_ERROR;
                            err     <= 1'b1;
                        end else if (accept && bus.in_last) begin
                            state_q <= S_DONE;
                            done    <= 1'b1;
                        end
                    end
                    // Release fetch one cycle into DONE, after the final write has been presented.
                    S_DONE:  core_hold <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            checksum <= '0;
        end else if (restart) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + bus.in_data;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads, scoreboarded memory writes, corner sequences.
module tb_imem_loader;
    import imem_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          gap;
        logic        start_in_gap;
    } vec_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic        start_a, start_b;
    logic        core_hold_a, core_hold_b;
    logic        done_a, done_b;
    logic        err_a, err_b;
    logic [31:0] word_count_a, word_count_b;
    logic [31:0] checksum_a, checksum_b;
    logic [1:0]  dbg_a, dbg_b;

    imem_loader_if if_a ();
    imem_loader_if if_b ();

    imem_loader #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0)) u_a (
        .CLK(CLK), .RST(RST), .start(start_a), .bus(if_a),
        .core_hold(core_hold_a), .done(done_a), .err(err_a),
        .word_count(word_count_a), .checksum(checksum_a), .dbg_state(dbg_a)
    );

    imem_loader #(.DEPTH_WORDS(2), .BASE_ADDR(32'h0)) u_b (
        .CLK(CLK), .RST(RST), .start(start_b), .bus(if_b),
        .core_hold(core_hold_b), .done(done_b), .err(err_b),
        .word_count(word_count_b), .checksum(checksum_b), .dbg_state(dbg_b)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          writes_a = 0;
    int          writes_b = 0;
    logic [63:0] exp_q_a[$];
    logic [63:0] exp_q_b[$];
    logic [31:0] addr_m_a, addr_m_b, sum_a, sum_b;
    vec_t        tbl[6];

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_ck(input logic [31:0] s);
        return CK_EN ? s : 32'h0;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start(input bit sel_b);
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        if (sel_b) begin addr_m_b = 32'h0; sum_b = 32'h0; end
        else       begin addr_m_a = 32'h0; sum_a = 32'h0; end
    endtask

    // Offers one word and waits (bounded) for the handshake; the expected write is queued on acceptance.
    task automatic send(input bit sel_b, input logic [31:0] data, input logic last);
        bit acc;
        acc = 1'b0;
        if (sel_b) begin if_b.in_valid = 1'b1; if_b.in_data = data; if_b.in_last = last; end
        else       begin if_a.in_valid = 1'b1; if_a.in_data = data; if_a.in_last = last; end
        for (int i = 0; i < 16 && !acc; i++) begin
            @(negedge CLK);
            if (!sel_b && if_a.in_ready === 1'b1) begin
                exp_q_a.push_back({addr_m_a, data});
                addr_m_a += 32'd4;
                sum_a    += data;
                acc = 1'b1;
            end else if (sel_b && if_b.in_ready === 1'b1) begin
                exp_q_b.push_back({addr_m_b, data});
                addr_m_b += 32'd4;
                sum_b    += data;
                acc = 1'b1;
            end
            step();
        end
        if (sel_b) if_b.in_valid = 1'b0; else if_a.in_valid = 1'b0;
        check(sel_b ? "b_word_accepted" : "a_word_accepted", 32'(acc), 32'd1);
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge CLK) begin
        logic [63:0] e;
        if (if_a.WE === 1'b1) begin
            writes_a++;
            if (exp_q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_write: got addr %h data %h expected no write", if_a.newPC, if_a.W_Ins);
            end else begin
                e = exp_q_a.pop_front();
                check("a_wr_addr", if_a.newPC, e[63:32]);
                check("a_wr_data", if_a.W_Ins, e[31:0]);
            end
        end
        if (if_b.WE === 1'b1) begin
            writes_b++;
            if (exp_q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_write: got addr %h data %h expected no write", if_b.newPC, if_b.W_Ins);
            end else begin
                e = exp_q_b.pop_front();
                check("b_wr_addr", if_b.newPC, e[63:32]);
                check("b_wr_data", if_b.W_Ins, e[31:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        tbl[0] = '{32'h20010005, 1'b0, 0, 1'b0};
        tbl[1] = '{32'h20020007, 1'b0, 0, 1'b0};
        tbl[2] = '{32'h00221820, 1'b1, 0, 1'b0};
        tbl[3] = '{32'h8C430000, 1'b0, 0, 1'b0};
        tbl[4] = '{32'hAC440004, 1'b0, 2, 1'b0};
        tbl[5] = '{32'h10000003, 1'b1, 2, 1'b1};

        RST = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.in_last = 1'b0;
        if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.in_last = 1'b0;
        addr_m_a = '0; addr_m_b = '0; sum_a = '0; sum_b = '0;

        // Reset state
        #2;
        check("rst_we",         if_a.WE,      32'd0);
        check("rst_w_ins",      if_a.W_Ins,   32'd0);
        check("rst_newpc",      if_a.newPC,   32'd0);
        check("rst_word_count", word_count_a, 32'd0);
        check("rst_checksum",   checksum_a,   32'd0);
        check("rst_core_hold",  core_hold_a,  32'd0);
        check("rst_done_err",   {done_a, err_a}, 32'd0);
        check("rst_in_ready",   if_a.in_ready, 32'd0);
        check("rst_state",      dbg_a,        IDLE);
        @(posedge CLK);
        #1 RST = 1'b1;
        step();

        // Single load, back-to-back words
        pulse_start(1'b0);
        @(negedge CLK);
        check("l1_hold_rise", core_hold_a, 32'd1);
        check("l1_state",     dbg_a,       LOAD);
        step();
        for (int i = 0; i < 3; i++) send(1'b0, tbl[i].data, tbl[i].last);
        @(negedge CLK);
        check("l1_word_count", word_count_a, 32'd3);
        check("l1_done",       done_a,       32'd1);
        check("l1_err",        err_a,        32'd0);
        check("l1_checksum",   checksum_a,   exp_ck(sum_a));
        step();
        @(negedge CLK);
        check("l1_hold_fall", core_hold_a,   32'd0);
        check("l1_ready_off", if_a.in_ready, 32'd0);
        check("l1_state_done", dbg_a,        DONE);
        step();
        check("l1_drained", 32'(exp_q_a.size()), 32'd0);
        check("l1_writes",  32'(writes_a),       32'd3);

        // Reload from DONE with backpressure gaps and an ignored start mid-load
        pulse_start(1'b0);
        @(negedge CLK);
        check("l2_count_clear", word_count_a, 32'd0);
        check("l2_done_clear",  done_a,       32'd0);
        check("l2_ck_clear",    checksum_a,   32'd0);
        step();
        for (int i = 3; i < 6; i++) begin
            for (int g = 0; g < tbl[i].gap; g++) begin
                if (tbl[i].start_in_gap && g == 1) start_a = 1'b1;
                @(negedge CLK);
                check("l2_gap_we",   if_a.WE,     32'(g == 0));
                check("l2_gap_hold", core_hold_a, 32'd1);
                step();
                start_a = 1'b0;
            end
            send(1'b0, tbl[i].data, tbl[i].last);
        end
        @(negedge CLK);
        check("l2_word_count", word_count_a, 32'd3);
        check("l2_done",       done_a,       32'd1);
        check("l2_checksum",   checksum_a,   exp_ck(sum_a));
        step();
        step();
        check("l2_drained", 32'(exp_q_a.size()), 32'd0);
        check("l2_writes",  32'(writes_a),       32'd6);

        // Overflow on the 2-word memory
        pulse_start(1'b1);
        send(1'b1, 32'h11111111, 1'b0);
        send(1'b1, 32'h22222222, 1'b0);
        if_b.in_valid = 1'b1; if_b.in_data = 32'h33333333; if_b.in_last = 1'b0;
        @(negedge CLK);
        check("ov_ready_drop", if_b.in_ready, 32'd0);
        check("ov_count_full", word_count_b,  32'd2);
        check("ov_err_early",  err_b,         32'd0);
        step();
        @(negedge CLK);
        check("ov_err",       err_b,         32'd1);
        check("ov_ready",     if_b.in_ready, 32'd0);
        check("ov_hold",      core_hold_b,   32'd1);
        check("ov_state",     dbg_b,         ERROR);
        check("ov_done",      done_b,        32'd0);
        check("ov_count_sat", word_count_b,  32'd2);
        step();
        if_b.in_valid = 1'b0;
        step();
        check("ov_drained", 32'(exp_q_b.size()), 32'd0);
        check("ov_writes",  32'(writes_b),       32'd2);
        pulse_start(1'b1);
        @(negedge CLK);
        check("ov_err_clear",   err_b,        32'd0);
        check("ov_count_clear", word_count_b, 32'd0);
        check("ov_reload",      dbg_b,        LOAD);
        step();

        // Last word landing exactly at capacity completes normally
        send(1'b1, 32'h44444444, 1'b0);
        send(1'b1, 32'h55555555, 1'b1);
        @(negedge CLK);
        check("bd_done",     done_b,       32'd1);
        check("bd_err",      err_b,        32'd0);
        check("bd_count",    word_count_b, 32'd2);
        check("bd_checksum", checksum_b,   exp_ck(sum_b));
        step();
        @(negedge CLK);
        check("bd_state", dbg_b,       DONE);
        check("bd_hold",  core_hold_b, 32'd0);
        step();
        check("bd_drained", 32'(exp_q_b.size()), 32'd0);
        check("bd_writes",  32'(writes_b),       32'd4);

        // Asynchronous reset in the middle of a load
        pulse_start(1'b0);
        send(1'b0, 32'hDEADBEEF, 1'b0);
        send(1'b0, 32'hCAFEF00D, 1'b0);
        #1;
        check("ar_pre_we",    if_a.WE,      32'd1);
        check("ar_pre_newpc", if_a.newPC,   32'd4);
        check("ar_pre_count", word_count_a, 32'd2);
        #1;
        RST = 1'b0;
        exp_q_a.delete();
        #1;
        check("ar_we",     if_a.WE,      32'd0);
        check("ar_newpc",  if_a.newPC,   32'd0);
        check("ar_count",  word_count_a, 32'd0);
        check("ar_hold",   core_hold_a,  32'd0);
        @(negedge CLK);
        #1 RST = 1'b1;
        step();
        @(negedge CLK);
        check("ar_state_idle", dbg_a,         IDLE);
        check("ar_ready",      if_a.in_ready, 32'd0);
        check("ar_done",       done_a,        32'd0);
        step();

        check("end_queue_a", 32'(exp_q_a.size()), 32'd0);
        check("end_queue_b", 32'(exp_q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
